// File: rtl/irrigation_zone_scheduler_if.sv
// Sensor and actuator bundle of the irrigation zone scheduler.
//   high/middle/low  tank level marks, 1 = water present
//   soil_dry         per-zone soil sensors, 1 = needs water
//   air_dry/temp_hot weather sensors selecting drip over sprinkler
//   erro/alarm       invalid level combination / tank empty or invalid
//   inlet_valve      tank fill valve
//   sprinkler/drip   one-hot zone valve enables
//   seg/digit_n      multiplexed 4-digit display, segments {g..a} active-high,
//                    digit enables active-low
// The slave modport is the scheduler, the master modport is whatever drives
// the sensors and observes the actuators.
interface irrigation_zone_scheduler_if #(
    parameter int N_ZONES = 4
);
    logic               high;
    logic               middle;
    logic               low;
    logic [N_ZONES-1:0] soil_dry;
    logic               air_dry;
    logic               temp_hot;
    logic               erro;
    logic               alarm;
    logic               inlet_valve;
    logic [N_ZONES-1:0] sprinkler;
    logic [N_ZONES-1:0] drip;
    logic [6:0]         seg;
    logic [3:0]         digit_n;

    modport master (
        output high, middle, low, soil_dry, air_dry, temp_hot,
        input  erro, alarm, inlet_valve, sprinkler, drip, seg, digit_n
    );

    modport slave (
        input  high, middle, low, soil_dry, air_dry, temp_hot,
        output erro, alarm, inlet_valve, sprinkler, drip, seg, digit_n
    );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Tank and irrigation controller: conditions the level/soil/weather sensors
// (2-flop synchroniser + per-bit debounce), validates the tank level, drives
// the inlet valve with hysteresis, serves one irrigation zone at a time in
// round-robin order with per-zone cooldowns, and scans a 4-digit display.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      sensors in / valves, alarm and display out (slave modport)
module irrigation_zone_scheduler #(
    parameter int N_ZONES     = 4,
    parameter int DEB_CYCLES  = 16,
    parameter int MAX_ON      = 1000,
    parameter int COOL_CYCLES = 200,
    parameter int SCAN_DIV    = 1000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    irrigation_zone_scheduler_if.slave   bus
);
    localparam int NI = N_ZONES + 5;
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int TW = (MAX_ON > 1) ? $clog2(MAX_ON) : 1;
    localparam int CW = (COOL_CYCLES > 0) ? $clog2(COOL_CYCLES + 1) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_S     = 7'h6D;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {IDLE, RUN, COOL} state_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [ZW-1:0] rr_zone(input logic [ZW-1:0] base, input int k);
        return ZW'((int'(base) + k) % N_ZONES);
    endfunction

    logic [NI-1:0]              raw, sync1_q, sync2_q, filt_q, filt_d;
    logic [NI-1:0][DW-1:0]      deb_q, deb_d;
    logic                       h, m, l, ad, th;
    logic [N_ZONES-1:0]         sd;
    logic                       erro_q, erro_d, alarm_q, alarm_d, inlet_q, inlet_d;
    state_t                     state_q, state_d;
    logic [ZW-1:0]              zone_q, zone_d, ptr_q, ptr_d, pick;
    logic                       found, stop;
    logic [TW-1:0]              timer_q, timer_d;
    logic [N_ZONES-1:0]         spr_q, spr_d, drip_q, drip_d;
    logic [N_ZONES-1:0][CW-1:0] cool_q, cool_d;
    logic [SW-1:0]              scan_q, scan_d;
    logic [1:0]                 dig_q, dig_d;
    logic [6:0]                 seg_q, seg_d;
    logic [3:0]                 digit_n_q, digit_n_d;
    logic [3:0]                 level;

    assign raw = {bus.temp_hot, bus.air_dry, bus.soil_dry, bus.low, bus.middle, bus.high};
    assign h   = filt_q[0];
    assign m   = filt_q[1];
    assign l   = filt_q[2];
    assign sd  = filt_q[3 +: N_ZONES];
    assign ad  = filt_q[N_ZONES + 3];
    assign th  = filt_q[N_ZONES + 4];

    // A filtered bit flips only after DEB_CYCLES consecutive synchronised
    // samples disagree with it; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        deb_d  = '0;
        for (int i = 0; i < NI; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_q[i] == DW'(DEB_CYCLES - 1)) filt_d[i] = sync2_q[i];
                else                                 deb_d[i] = deb_q[i] + DW'(1);
            end
        end
    end

    always_comb begin
        erro_d  = (h & ~m) | (m & ~l) | (h & ~l);
        alarm_d = ~l | erro_d;
        inlet_d = inlet_q;
        if (h | erro_d)  inlet_d = 1'b0;
        else if (~m)     inlet_d = 1'b1;
    end

    // First dry, non-cooling zone at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_ZONES; k++) begin
            if (!found && sd[rr_zone(ptr_q, k)] && (cool_q[rr_zone(ptr_q, k)] == '0)) begin
                found = 1'b1;
                pick  = rr_zone(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        zone_d  = zone_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        spr_d   = spr_q;
        drip_d  = drip_q;
        stop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!alarm_q && found) begin
                    state_d = RUN;
                    zone_d  = pick;
                    timer_d = '0;
                    if (th | ad | ~m) drip_d = N_ZONES'(1) << pick;
                    else              spr_d  = N_ZONES'(1) << pick;
                end
            end
            RUN: begin
                if (!sd[zone_q] || (timer_q == TW'(MAX_ON - 1)) || alarm_q) begin
                    state_d = COOL;
                    spr_d   = '0;
                    drip_d  = '0;
                    stop    = 1'b1;
                    ptr_d   = (zone_q == ZW'(N_ZONES - 1)) ? '0 : zone_q + ZW'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int z = 0; z < N_ZONES; z++) begin
            if (stop && (zone_q == ZW'(z)))  cool_d[z] = CW'(COOL_CYCLES);
            else if (cool_q[z] != '0)        cool_d[z] = cool_q[z] - CW'(1);
            else                             cool_d[z] = '0;
        end
    end

    // Display content is taken from next-state values so the digit shown
    // after an edge matches the valves and flags visible after that edge.
    always_comb begin
        level = {3'b000, l} + {3'b000, m} + {3'b000, h};
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            dig_d  = dig_q + 2'd1;
        end else begin
            scan_d = scan_q + SW'(1);
            dig_d  = dig_q;
        end
        case (dig_d)
            2'd0:    seg_d = erro_d ? SEG_E : seg_digit(level);
            2'd1:    seg_d = (state_d == IDLE) ? SEG_DASH : seg_digit(4'(zone_d) + 4'd1);
            2'd2:    seg_d = (|spr_d) ? SEG_S : ((|drip_d) ? SEG_D : SEG_DASH);
            default: seg_d = alarm_d ? SEG_A : SEG_BLANK;
        endcase
        digit_n_d = ~(4'b0001 << dig_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            deb_q     <= '0;
            erro_q    <= 1'b0;
            alarm_q   <= 1'b0;
            inlet_q   <= 1'b0;
            state_q   <= IDLE;
            zone_q    <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
            spr_q     <= '0;
            drip_q    <= '0;
            cool_q    <= '0;
            scan_q    <= '0;
            dig_q     <= 2'd0;
            seg_q     <= 7'h00;
            digit_n_q <= 4'b1110;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            deb_q     <= deb_d;
            erro_q    <= erro_d;
            alarm_q   <= alarm_d;
            inlet_q   <= inlet_d;
            state_q   <= state_d;
            zone_q    <= zone_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            spr_q     <= spr_d;
            drip_q    <= drip_d;
            cool_q    <= cool_d;
            scan_q    <= scan_d;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
            digit_n_q <= digit_n_d;
        end
    end

    assign bus.erro        = erro_q;
    assign bus.alarm       = alarm_q;
    assign bus.inlet_valve = inlet_q;
    assign bus.sprinkler   = spr_q;
    assign bus.drip        = drip_q;
    assign bus.seg         = seg_q;
    assign bus.digit_n     = digit_n_q;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
module tb_irrigation_zone_scheduler;
    logic clk;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   viol  = 0;

    irrigation_zone_scheduler_if #(.N_ZONES(4)) bus ();

    irrigation_zone_scheduler #(
        .N_ZONES(4), .DEB_CYCLES(2), .MAX_ON(8), .COOL_CYCLES(20), .SCAN_DIV(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valve and digit-enable invariants, sampled every cycle out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            if (((bus.sprinkler & bus.drip) != 0) || ($countones(bus.sprinkler | bus.drip) > 1) ||
                ($countones(~bus.digit_n) != 1))
                viol++;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic m, input logic l, input logic [3:0] sd,
                          input logic ad, input logic th);
        bus.high = h; bus.middle = m; bus.low = l;
        bus.soil_dry = sd; bus.air_dry = ad; bus.temp_hot = th;
    endtask

    logic [6:0] seg0, seg1, seg2, seg3;
    int         run_len, nrun, act;
    logic [3:0] prev, zones [4];
    int         t_start [4];
    int         t_end [4];
    logic       spr_seen;

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 4'b0000, 0, 0);
        repeat (3) @(negedge clk);
        check_vec("rst_sprinkler", bus.sprinkler, 4'b0000);
        check_vec("rst_drip", bus.drip, 4'b0000);
        check_vec("rst_inlet", bus.inlet_valve, 1'b0);
        check_vec("rst_alarm", bus.alarm, 1'b0);
        check_vec("rst_erro", bus.erro, 1'b0);
        check_vec("rst_seg", bus.seg, 7'h00);
        check_vec("rst_digit_n", bus.digit_n, 4'b1110);

        // Empty tank after reset: alarm and fill.
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("empty_alarm", bus.alarm, 1'b1);
        check_vec("empty_inlet", bus.inlet_valve, 1'b1);

        // Full tank, zone 2 dry, cool and humid: sprinkler after sync+debounce.
        set_in(1, 1, 1, 4'b0100, 0, 0);
        repeat (5) @(negedge clk);
        check_vec("full_inlet_off", bus.inlet_valve, 1'b0);
        check_vec("full_alarm_off", bus.alarm, 1'b0);
        check_vec("pre_run_sprinkler", bus.sprinkler, 4'b0000);
        @(negedge clk);
        check_vec("run_sprinkler", bus.sprinkler, 4'b0100);
        check_vec("run_drip", bus.drip, 4'b0000);
        run_len = 0;
        seg0 = 7'h7F; seg1 = 7'h7F; seg2 = 7'h7F; seg3 = 7'h7F;
        for (int i = 0; i < 20 && bus.sprinkler != 0; i++) begin
            run_len++;
            case (bus.digit_n)
                4'b1110: seg0 = bus.seg;
                4'b1101: seg1 = bus.seg;
                4'b1011: seg2 = bus.seg;
                4'b0111: seg3 = bus.seg;
                default: ;
            endcase
            @(negedge clk);
        end
        check_vec("run_len_max_on", run_len, 8);
        check_vec("disp_level3", seg0, 7'h4F);
        check_vec("disp_zone3", seg1, 7'h4F);
        check_vec("disp_mode_S", seg2, 7'h6D);
        check_vec("disp_no_alarm", seg3, 7'h00);

        // Next run of zone 2; break the level sensors during it.
        for (int i = 0; i < 40 && bus.sprinkler == 0; i++) @(negedge clk);
        check_vec("rerun_sprinkler", bus.sprinkler, 4'b0100);
        set_in(1, 0, 1, 4'b0100, 0, 0);
        for (int i = 0; i < 10 && !bus.erro; i++) @(negedge clk);
        check_vec("bad_level_erro", bus.erro, 1'b1);
        check_vec("bad_level_alarm", bus.alarm, 1'b1);
        @(negedge clk);
        check_vec("alarm_stop_spr", bus.sprinkler, 4'b0000);
        check_vec("alarm_stop_drip", bus.drip, 4'b0000);
        check_vec("erro_inlet_off", bus.inlet_valve, 1'b0);
        for (int i = 0; i < 10 && bus.digit_n != 4'b1110; i++) @(negedge clk);
        check_vec("disp_E", bus.seg, 7'h79);
        for (int i = 0; i < 10 && bus.digit_n != 4'b0111; i++) @(negedge clk);
        check_vec("disp_A", bus.seg, 7'h77);

        // Inlet hysteresis between the middle and high marks.
        set_in(0, 0, 1, 4'b0000, 0, 0);
        repeat (8) @(negedge clk);
        check_vec("low_erro_clear", bus.erro, 1'b0);
        check_vec("low_inlet_on", bus.inlet_valve, 1'b1);
        set_in(0, 1, 1, 4'b0000, 0, 0);
        repeat (8) @(negedge clk);
        check_vec("rising_inlet_hold", bus.inlet_valve, 1'b1);
        set_in(1, 1, 1, 4'b0000, 0, 0);
        repeat (8) @(negedge clk);
        check_vec("high_inlet_off", bus.inlet_valve, 1'b0);
        set_in(0, 1, 1, 4'b0000, 0, 0);
        repeat (8) @(negedge clk);
        check_vec("falling_inlet_hold", bus.inlet_valve, 1'b0);

        // One-cycle glitch on a soil sensor must not start a zone.
        bus.soil_dry = 4'b0010;
        @(negedge clk);
        bus.soil_dry = 4'b0000;
        act = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if ((bus.sprinkler | bus.drip) != 0) act = 1;
        end
        check_vec("glitch_no_valve", act, 0);

        // Dry air selects drip; reset pulsed mid-run drops the valve at once.
        set_in(1, 1, 1, 4'b0001, 1, 0);
        for (int i = 0; i < 20 && bus.drip == 0; i++) @(negedge clk);
        check_vec("drip_zone0", bus.drip, 4'b0001);
        check_vec("drip_no_spr", bus.sprinkler, 4'b0000);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_vec("rst_mid_drip", bus.drip, 4'b0000);
        check_vec("rst_mid_spr", bus.sprinkler, 4'b0000);
        set_in(1, 1, 1, 4'b1001, 0, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_vec("rel_digit_n", bus.digit_n, 4'b1110);

        // Round robin across zones 0 and 3 with cooldowns, starting at pointer 0.
        nrun = 0; prev = 4'b0000; spr_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin zones[k] = 4'b0000; t_start[k] = 0; t_end[k] = 0; end
        for (int c = 0; c < 300 && nrun < 4; c++) begin
            @(negedge clk);
            if (bus.drip != 0 && prev == 0) begin zones[nrun] = bus.drip; t_start[nrun] = c; end
            if (bus.drip == 0 && prev != 0) begin t_end[nrun] = c; nrun++; end
            if (bus.sprinkler != 0) spr_seen = 1'b1;
            prev = bus.drip;
        end
        check_vec("rr_runs", nrun, 4);
        check_vec("rr_zone_a", zones[0], 4'b0001);
        check_vec("rr_zone_b", zones[1], 4'b1000);
        check_vec("rr_zone_c", zones[2], 4'b0001);
        check_vec("rr_zone_d", zones[3], 4'b1000);
        for (int k = 0; k < 4; k++) check_vec($sformatf("rr_len%0d", k), t_end[k] - t_start[k], 8);
        check_vec("rr_cool_gap", (t_start[2] - t_end[0]) >= 20, 1'b1);
        check_vec("rr_no_spr", spr_seen, 1'b0);

        check_vec("valve_digit_invariant", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
